// File: rtl/trap_integrator_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trap_integrator_stage_if : sample/control/status bundle of the integrator
// Rev 1.0
// ---------------------------------------------------------------------------
interface trap_integrator_stage_if #(
  parameter int IN_W      = 22,
  parameter int ACC_W     = 26,
  parameter int OUT_SHIFT = 0,
  parameter int CNT_W     = 16
);
  logic                               CLR;
  logic                               HOLD;
  logic                               IN_VALID;
  logic signed [IN_W-1:0]             DATAIN;
  logic                               OVF_CLR;
  logic                               OUT_VALID;
  logic signed [ACC_W-OUT_SHIFT-1:0]  DATAOUT;
  logic                               ACC_OVF;
  logic [CNT_W-1:0]                   SAMPLE_CNT;

  modport master (
    output CLR, HOLD, IN_VALID, DATAIN, OVF_CLR,
    input  OUT_VALID, DATAOUT, ACC_OVF, SAMPLE_CNT
  );

  modport slave (
    input  CLR, HOLD, IN_VALID, DATAIN, OVF_CLR,
    output OUT_VALID, DATAOUT, ACC_OVF, SAMPLE_CNT
  );
endinterface
`default_nettype wire

// File: rtl/trap_integrator_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trap_integrator_stage : wrap/saturate accumulator with rounded, shifted output
// Rev 1.0
// ---------------------------------------------------------------------------
module trap_integrator_stage #(
  parameter int IN_W      = 22,
  parameter int ACC_W     = 26,
  parameter int OUT_SHIFT = 0,
  parameter int SAT_EN    = 0,
  parameter int CNT_W     = 16
) (
  input  wire logic              SYS_CLK,
  input  wire logic              RESET_N,
  trap_integrator_stage_if.slave bus
);

  localparam int c_out_w = ACC_W - OUT_SHIFT;
  localparam int c_ext_w = ACC_W + 1 - IN_W;
  localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      v1_q, v1_d;
  logic signed [c_out_w-1:0] dout_q, dout_d;
  logic                      oval_q, oval_d;
  logic                      ovf_q, ovf_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic                      w_accept;
  logic [ACC_W:0]            w_sum;
  logic                      w_sum_ovf;
  logic signed [c_out_w-1:0] w_rnd;

  assign w_accept  = bus.IN_VALID & ~bus.HOLD & ~bus.CLR;
  // One guard bit: the top two bits of the sum disagree exactly on overflow.
  assign w_sum     = {acc_q[ACC_W-1], acc_q} + {{c_ext_w{bus.DATAIN[IN_W-1]}}, bus.DATAIN};
  assign w_sum_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  generate
    if (OUT_SHIFT == 0) begin : g_round_pass
      assign w_rnd = acc_q;
    end else begin : g_round_half_up
      localparam logic [c_out_w-1:0] c_out_max = {1'b0, {(c_out_w-1){1'b1}}};
      logic [c_out_w:0] w_rsum;
      // Adding half an LSB then shifting equals floor-shift plus the first dropped bit.
      assign w_rsum = {acc_q[ACC_W-1], acc_q[ACC_W-1:OUT_SHIFT]}
                    + {{c_out_w{1'b0}}, acc_q[OUT_SHIFT-1]};
      assign w_rnd  = (w_rsum[c_out_w] ^ w_rsum[c_out_w-1]) ? c_out_max
                                                            : w_rsum[c_out_w-1:0];
    end
  endgenerate

  always_comb begin
    acc_d  = acc_q;
    v1_d   = w_accept;
    dout_d = dout_q;
    oval_d = 1'b0;
    ovf_d  = ovf_q & ~bus.OVF_CLR;
    cnt_d  = cnt_q;
    if (bus.CLR) begin
      acc_d  = '0;
      dout_d = '0;
      cnt_d  = '0;
    end else begin
      if (w_accept) begin
        if (w_sum_ovf && (SAT_EN != 0)) begin
          acc_d = w_sum[ACC_W] ? c_acc_min : c_acc_max;
        end else begin
          acc_d = w_sum[ACC_W-1:0];
        end
        if (w_sum_ovf) begin
          ovf_d = 1'b1;
        end
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      if (v1_q) begin
        dout_d = w_rnd;
        oval_d = 1'b1;
      end
    end
  end

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc_q  <= '0;
      v1_q   <= 1'b0;
      dout_q <= '0;
      oval_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      v1_q   <= v1_d;
      dout_q <= dout_d;
      oval_q <= oval_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.OUT_VALID  = oval_q;
  assign bus.DATAOUT    = dout_q;
  assign bus.ACC_OVF    = ovf_q;
  assign bus.SAMPLE_CNT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_trap_integrator_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_trap_integrator_stage : vector table + scoreboard for three configurations
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_trap_integrator_stage;

  localparam int IN_W  = 22;
  localparam int ACC_W = 26;
  localparam longint c_in_max = 2097151;   // 2^21-1
  localparam longint c_in_min = -2097152;  // -2^21

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default config, saturating config, shifted config with a tiny counter
  trap_integrator_stage_if #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_SHIFT(0), .CNT_W(16)) if_def ();
  trap_integrator_stage_if #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_SHIFT(0), .CNT_W(16)) if_sat ();
  trap_integrator_stage_if #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_SHIFT(2), .CNT_W(3))  if_shf ();

  trap_integrator_stage #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_SHIFT(0), .SAT_EN(0), .CNT_W(16))
    u_def (.SYS_CLK(clk), .RESET_N(rst_n), .bus(if_def));
  trap_integrator_stage #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_SHIFT(0), .SAT_EN(1), .CNT_W(16))
    u_sat (.SYS_CLK(clk), .RESET_N(rst_n), .bus(if_sat));
  trap_integrator_stage #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_SHIFT(2), .SAT_EN(0), .CNT_W(3))
    u_shf (.SYS_CLK(clk), .RESET_N(rst_n), .bus(if_shf));

  int checks   = 0;
  int failures = 0;

  longint q_def[$];
  longint q_sat[$];
  longint q_shf[$];

  typedef struct {
    bit     clr;
    bit     hold;
    bit     vld;
    longint din;
    bit     oclr;
    bit     exp_v;
    longint exp_out;
    longint exp_cnt;
    bit     exp_ovf;
    bit     exp_zero;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit clr, bit hold, bit vld, longint din, bit oclr,
                              bit exp_v, longint exp_out, longint exp_cnt,
                              bit exp_ovf, bit exp_zero);
    vec_t v;
    v.clr = clr; v.hold = hold; v.vld = vld; v.din = din; v.oclr = oclr;
    v.exp_v = exp_v; v.exp_out = exp_out; v.exp_cnt = exp_cnt;
    v.exp_ovf = exp_ovf; v.exp_zero = exp_zero;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic signed [63:0] act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input bit clr, input bit hold, input bit vld,
                       input longint din, input bit oclr);
    if_def.CLR = 1'b0; if_def.HOLD = 1'b0; if_def.IN_VALID = 1'b0; if_def.DATAIN = '0; if_def.OVF_CLR = 1'b0;
    if_sat.CLR = 1'b0; if_sat.HOLD = 1'b0; if_sat.IN_VALID = 1'b0; if_sat.DATAIN = '0; if_sat.OVF_CLR = 1'b0;
    if_shf.CLR = 1'b0; if_shf.HOLD = 1'b0; if_shf.IN_VALID = 1'b0; if_shf.DATAIN = '0; if_shf.OVF_CLR = 1'b0;
    case (which)
      0: begin
        if_def.CLR = clr; if_def.HOLD = hold; if_def.IN_VALID = vld;
        if_def.DATAIN = IN_W'(din); if_def.OVF_CLR = oclr;
      end
      1: begin
        if_sat.CLR = clr; if_sat.HOLD = hold; if_sat.IN_VALID = vld;
        if_sat.DATAIN = IN_W'(din); if_sat.OVF_CLR = oclr;
      end
      2: begin
        if_shf.CLR = clr; if_shf.HOLD = hold; if_shf.IN_VALID = vld;
        if_shf.DATAIN = IN_W'(din); if_shf.OVF_CLR = oclr;
      end
      default: ;
    endcase
  endtask

  task automatic push(input int which, input longint v);
    case (which)
      0: q_def.push_back(v);
      1: q_sat.push_back(v);
      default: q_shf.push_back(v);
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int which, input longint din, input longint exp, input bit oclr);
    drive(which, 1'b0, 1'b0, 1'b1, din, oclr);
    push(which, exp);
    tick();
  endtask

  task automatic idle(input int which, input bit clr, input bit oclr);
    drive(which, clr, 1'b0, 1'b0, 0, oclr);
    tick();
  endtask

  // Output monitors: every OUT_VALID pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (if_def.OUT_VALID === 1'b1) begin
      if (q_def.size() == 0) check("def_unexpected_out_valid", 1, 0);
      else check("def_dataout", if_def.DATAOUT, q_def.pop_front());
    end
  end
  always @(negedge clk) begin
    if (if_sat.OUT_VALID === 1'b1) begin
      if (q_sat.size() == 0) check("sat_unexpected_out_valid", 1, 0);
      else check("sat_dataout", if_sat.DATAOUT, q_sat.pop_front());
    end
  end
  always @(negedge clk) begin
    if (if_shf.OUT_VALID === 1'b1) begin
      if (q_shf.size() == 0) check("shf_unexpected_out_valid", 1, 0);
      else check("shf_dataout", if_shf.DATAOUT, q_shf.pop_front());
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    longint s;
    longint e;
    vec_t   v;

    // Default-config vectors: outputs, count and flag after each edge.
    add(0,0,1, 5,0, 1, 5, 1,0,0);
    add(0,0,1,-3,0, 1, 2, 2,0,0);
    add(0,0,1,10,0, 1,12, 3,0,0);
    add(0,0,0, 0,0, 0, 0, 3,0,0);
    add(0,0,1, 7,0, 1,19, 4,0,0);
    add(0,1,1, 7,0, 0, 0, 4,0,0);
    add(0,1,1, 7,0, 0, 0, 4,0,0);
    add(0,1,1, 7,0, 0, 0, 4,0,0);
    add(0,0,0, 0,0, 0, 0, 4,0,0);
    add(0,0,1, 1,0, 1,20, 5,0,0);
    add(0,0,0, 0,0, 0, 0, 5,0,0);
    add(1,0,1,100,0, 0, 0, 0,0,1);
    add(0,0,1, 1,0, 1, 1, 1,0,0);
    add(0,0,0, 0,0, 0, 0, 1,0,0);
    for (int i = 0; i < 16; i++) begin
      add(0,0,1, c_in_max,0, 1, 1 + (i + 1) * c_in_max, 2 + i, 0, 0);
    end
    add(0,0,1,13,0, 1, 33554430, 18,0,0);
    add(0,0,1, 4,0, 1,-33554430, 19,1,0);
    add(0,0,0, 0,0, 0, 0, 19,1,0);
    add(0,0,0, 0,1, 0, 0, 19,0,0);

    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", if_def.OUT_VALID, 0);
    check("reset_dataout",   if_def.DATAOUT,   0);
    check("reset_acc_ovf",   if_def.ACC_OVF,   0);
    check("reset_cnt",       if_def.SAMPLE_CNT, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(0, v.clr, v.hold, v.vld, v.din, v.oclr);
      if (v.exp_v) push(0, v.exp_out);
      tick();
      check("def_sample_cnt", if_def.SAMPLE_CNT, v.exp_cnt);
      check("def_acc_ovf",    if_def.ACC_OVF,    v.exp_ovf);
      if (v.exp_zero) begin
        check("def_clr_dataout",   if_def.DATAOUT,   0);
        check("def_clr_out_valid", if_def.OUT_VALID, 0);
      end
    end

    // Saturating config: clamp high, set-beats-clear, then clamp low.
    for (int i = 0; i < 16; i++) feed(1, c_in_max, (i + 1) * c_in_max, 0);
    feed(1, 14, 33554430, 0);
    check("sat_no_ovf_yet", if_sat.ACC_OVF, 0);
    feed(1, 4, 33554431, 0);
    check("sat_pos_ovf", if_sat.ACC_OVF, 1);
    feed(1, 1, 33554431, 1);
    check("sat_ovf_set_wins", if_sat.ACC_OVF, 1);
    idle(1, 0, 1);
    check("sat_ovf_clr", if_sat.ACC_OVF, 0);
    check("sat_cnt", if_sat.SAMPLE_CNT, 19);
    idle(1, 1, 0);
    check("sat_clr_cnt", if_sat.SAMPLE_CNT, 0);
    for (int i = 0; i < 16; i++) feed(1, c_in_min, (i + 1) * c_in_min, 0);
    check("sat_min_exact_no_ovf", if_sat.ACC_OVF, 0);
    feed(1, -1, -33554432, 0);
    check("sat_neg_ovf", if_sat.ACC_OVF, 1);
    idle(1, 0, 0);

    // Shifted config: round half up, negative values, output clamp, counter saturation.
    feed(2, 6, 2, 0);
    feed(2, 1, 2, 0);
    check("shf_cnt2", if_shf.SAMPLE_CNT, 2);
    idle(2, 0, 0);
    idle(2, 1, 0);
    check("shf_clr_dataout", if_shf.DATAOUT, 0);
    feed(2, -2, 0, 0);
    feed(2, -3, -1, 0);
    feed(2, 11, 2, 0);
    idle(2, 0, 0);
    idle(2, 1, 0);
    for (int i = 0; i < 16; i++) begin
      s = (i + 1) * c_in_max;
      e = (s + 2) >>> 2;
      if (e > 8388607) e = 8388607;
      feed(2, c_in_max, e, 0);
    end
    feed(2, 15, 8388607, 0);
    check("shf_cnt_saturates", if_shf.SAMPLE_CNT, 7);
    check("shf_no_ovf", if_shf.ACC_OVF, 0);
    idle(2, 0, 0);
    idle(2, 0, 0);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_def_dataout",   if_def.DATAOUT,    0);
    check("areset_def_out_valid", if_def.OUT_VALID,  0);
    check("areset_def_cnt",       if_def.SAMPLE_CNT, 0);
    check("areset_sat_dataout",   if_sat.DATAOUT,    0);
    check("areset_sat_ovf",       if_sat.ACC_OVF,    0);
    check("areset_shf_cnt",       if_shf.SAMPLE_CNT, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    feed(0, 9, 9, 0);
    check("post_reset_cnt", if_def.SAMPLE_CNT, 1);
    check("post_reset_ovf", if_def.ACC_OVF, 0);
    feed(1, -9, -9, 0);
    idle(1, 0, 0);
    repeat (3) tick();

    check("def_queue_drained", q_def.size(), 0);
    check("sat_queue_drained", q_sat.size(), 0);
    check("shf_queue_drained", q_shf.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trap_integrator_stage.md
Name: trap_integrator_stage

Overview:
Parametrised successor to the trapezoidal filter's stage-3 integrator. Accumulates signed samples from the difference stages, with a valid qualifier, hold and clear controls, and a selectable wrap or saturate mode. A sticky overflow flag and a sample counter report accumulator state. The output is registered and rounded-shifted, so it can drive the pole-zero/scaling stage or the peak detector directly.

Parameters:
IN_W, 22, signed input width
ACC_W, 26, signed accumulator width; must be greater than IN_W
OUT_SHIFT, 0, arithmetic right shift applied at the output, range 0..ACC_W-2
SAT_EN, 0, 0 = two's-complement wrap on overflow, 1 = clamp to ACC_W limits
CNT_W, 16, width of the accepted-sample counter

Ports:
SYS_CLK  in  1  system clock; all state changes on its rising edge
RESET_N  in  1  asynchronous, active-low reset
CLR  in  1  synchronous clear of the accumulator, output pipe and counter
HOLD  in  1  freeze accumulator; input samples are ignored while high
IN_VALID  in  1  DATAIN is valid this cycle
DATAIN  in  IN_W  signed input sample
OVF_CLR  in  1  synchronous clear of the sticky overflow flag
OUT_VALID  out  1  one-cycle pulse; DATAOUT updated this cycle
DATAOUT  out  ACC_W-OUT_SHIFT  signed, rounded, shifted accumulator value
ACC_OVF  out  1  sticky flag: an accumulation overflowed
SAMPLE_CNT  out  CNT_W  number of samples accepted since the last clear/reset

Behaviour:
- Reset (RESET_N low, asynchronous): acc, DATAOUT, OUT_VALID, ACC_OVF and SAMPLE_CNT all go to 0 immediately, independent of SYS_CLK.
- Accept condition: IN_VALID=1, HOLD=0 and CLR=0.
- Stage 1 (accumulator), priority CLR > HOLD > accept:
  - CLR: acc <= 0.
  - Accept: form sum = acc + sign-extended DATAIN at ACC_W+1 bits. Overflow is detected when the top two bits of sum differ.
    - No overflow: acc <= sum[ACC_W-1:0].
    - Overflow with SAT_EN=0: acc <= sum[ACC_W-1:0] (wraps).
    - Overflow with SAT_EN=1: acc <= +2^(ACC_W-1)-1 on positive overflow, -2^(ACC_W-1) on negative overflow.
  - Otherwise (HOLD, or no valid sample): acc holds its value.
- Stage 2 (output), registered one cycle after stage 1. The valid pipeline bit v1 is set on accept.
  - When v1=1: DATAOUT <= round(acc) and OUT_VALID <= 1. Otherwise OUT_VALID <= 0 and DATAOUT holds.
  - round(): for OUT_SHIFT=0, pass acc through unchanged. For OUT_SHIFT>0, compute (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT at ACC_W+1 bits, then clamp to the maximum positive DATAOUT value if the addition overflowed (round half up).
- Latency: a sample accepted at edge k appears on DATAOUT with OUT_VALID=1 after edge k+1. Throughput is one sample per cycle.
- CLR: clears acc and v1. At the next edge DATAOUT <= 0 and OUT_VALID <= 0; a sample that was in flight is discarded. SAMPLE_CNT <= 0. ACC_OVF is unaffected.
- ACC_OVF: set on any accepted overflow in either SAT_EN mode.
  - Cleared by OVF_CLR.
  - If an overflow and OVF_CLR occur in the same cycle, set wins.
- SAMPLE_CNT: increments on each accept and saturates at 2^CNT_W-1 (no wrap).
- HOLD does not flush stage 2: a sample accepted the cycle before HOLD rises still produces its OUT_VALID pulse.
- RESET_N deasserted mid-stream: the first accepted sample after reset produces DATAOUT = that sample (sign-extended, rounded).

Test Plan:
1. Defaults; reset, then inputs 5, -3, 10 on consecutive cycles -> DATAOUT 5, 2, 12 with OUT_VALID high for 3 cycles, starting 2 edges after the first input; SAMPLE_CNT=3.
2. SAT_EN=0, acc preloaded to 2^25-2 by feeding samples, then input +4 -> DATAOUT = -2^25+2, ACC_OVF=1. Repeat with SAT_EN=1 -> DATAOUT = 2^25-1, ACC_OVF=1. Then OVF_CLR -> ACC_OVF=0.
3. HOLD high for 3 cycles with IN_VALID=1, DATAIN=7 -> acc unchanged and SAMPLE_CNT unchanged; OUT_VALID pulses only for the sample accepted before HOLD rose.
4. CLR asserted in the same cycle as IN_VALID with DATAIN=100 -> sample ignored, DATAOUT=0 and OUT_VALID=0 next cycle; next input 1 -> DATAOUT=1.
5. OUT_SHIFT=2; inputs 6 then 1 -> acc 6 then 7 -> DATAOUT 2 (6+2=8>>2) then 2 (7+2=9>>2). Input -2 from acc 0 -> DATAOUT 0 (-2+2=0).
6. RESET_N pulsed low between clock edges mid-stream -> all outputs 0 asynchronously. After release, input 9 -> DATAOUT 9, SAMPLE_CNT=1, ACC_OVF=0.
